dadda_pipe_mul: RTL and testbench

Parametrised, pipelined Dadda-tree multiplier with a valid/ready stream interface and per-transaction signed/unsigned mode. It is the sequential successor to the fixed 8x8 combinational Dadda multiplier. It keeps the same carry-save reduction core, generalised to N x M operands and registered into three stages so it can sit on a streaming datapath at full clock rate.

---
 rtl/dadda_pipe_mul_if.sv | 24 ++
 rtl/dadda_pipe_mul.sv | 149 ++++++++++++++
 tb/tb_dadda_pipe_mul.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dadda_pipe_mul_if.sv
// Stream bundle for dadda_pipe_mul: operand channel in, product channel out.
interface dadda_pipe_mul_if #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     A;
    logic [M-1:0]     B;
    logic             signed_mode;
    logic             out_valid;
    logic             out_ready;
    logic [N+M-1:0]   y;

    modport master (
        output in_valid, A, B, signed_mode, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, A, B, signed_mode, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/dadda_pipe_mul.sv
// Three-stage N x M Dadda-tree multiplier; per-transaction signed (Baugh-Wooley) or unsigned.
// S1 registers operands, S2 reduces partial products to two rows, S3 adds them into y.
module dadda_pipe_mul #(
    parameter int unsigned N = 8,
    parameter int unsigned M = 8
) (
    input  logic            clk,
    input  logic            rst,
    dadda_pipe_mul_if.slave bus
);
    localparam int unsigned W    = N + M;
    localparam int unsigned ROWS = ((N < M) ? N : M) + 2;
    localparam int unsigned NSTG = 8;
    localparam int DADDA [NSTG] = '{28, 19, 13, 9, 6, 4, 3, 2};

    logic             stall;
    logic             v1, v2, v3;
    logic [N-1:0]     a1;
    logic [M-1:0]     b1;
    logic             s1;
    logic [W-1:0]     r0_q, r1_q, y_q;
    logic [W-1:0]     row0_c, row1_c;

    // Columns are bit multisets packed at the LSB end; order inside a column is irrelevant.
    logic [ROWS-1:0]  col [W];
    logic [ROWS-1:0]  nxt [W];
    int               cnt [W];
    int               ncnt [W];
    int               rem;
    logic             pa, pb, pc, sum, cy;

    assign stall         = v3 && !bus.out_ready;
    assign bus.in_ready  = !stall && !rst;
    assign bus.out_valid = v3;
    assign bus.y         = y_q;

    // Partial-product generation and Dadda carry-save reduction down to two rows.
    always_comb begin
        for (int i = 0; i < W; i++) begin
            col[i]  = '0;
            nxt[i]  = '0;
            cnt[i]  = 0;
            ncnt[i] = 0;
        end
        rem    = 0;
        pa     = 1'b0;
        pb     = 1'b0;
        pc     = 1'b0;
        sum    = 1'b0;
        cy     = 1'b0;
        row0_c = '0;
        row1_c = '0;

        // Baugh-Wooley: invert terms in the MSB row/column except the corner.
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < M; j++) begin
                pa = a1[i] & b1[j];
                if (s1 && ((i == N - 1) != (j == M - 1))) pa = ~pa;
                col[i+j] = {col[i+j][ROWS-2:0], pa};
                cnt[i+j] = cnt[i+j] + 1;
            end
        end
        // Correction constants 2^(N-1) + 2^(M-1) + 2^(N+M-1) (mod 2^(N+M)).
        if (s1) begin
            col[N-1] = {col[N-1][ROWS-2:0], 1'b1};
            cnt[N-1] = cnt[N-1] + 1;
            col[M-1] = {col[M-1][ROWS-2:0], 1'b1};
            cnt[M-1] = cnt[M-1] + 1;
            col[W-1] = {col[W-1][ROWS-2:0], 1'b1};
            cnt[W-1] = cnt[W-1] + 1;
        end

        for (int s = 0; s < NSTG; s++) begin
            for (int i = 0; i < W; i++) begin
                nxt[i]  = '0;
                ncnt[i] = 0;
            end
            for (int i = 0; i < W; i++) begin
                rem = cnt[i];
                for (int k = 0; k < ROWS; k++) begin
                    if ((rem + ncnt[i] > DADDA[s]) && (rem >= 2)) begin
                        pa = col[i][0];
                        pb = col[i][1];
                        if ((rem + ncnt[i] == DADDA[s] + 1) || (rem < 3)) begin
                            col[i] = col[i] >> 2;
                            rem    = rem - 2;
                            sum    = pa ^ pb;
                            cy     = pa & pb;
                        end else begin
                            pc     = col[i][2];
                            col[i] = col[i] >> 3;
                            rem    = rem - 3;
                            sum    = pa ^ pb ^ pc;
                            cy     = (pa & pb) | (pc & (pa ^ pb));
                        end
                        nxt[i]  = {nxt[i][ROWS-2:0], sum};
                        ncnt[i] = ncnt[i] + 1;
                        if (i + 1 < W) begin
                            nxt[i+1]  = {nxt[i+1][ROWS-2:0], cy};
                            ncnt[i+1] = ncnt[i+1] + 1;
                        end
                    end
                end
                for (int k = 0; k < ROWS; k++) begin
                    if (rem > 0) begin
                        nxt[i]  = {nxt[i][ROWS-2:0], col[i][0]};
                        ncnt[i] = ncnt[i] + 1;
                        col[i]  = col[i] >> 1;
                        rem     = rem - 1;
                    end
                end
            end
            for (int i = 0; i < W; i++) begin
                col[i] = nxt[i];
                cnt[i] = ncnt[i];
            end
        end

        for (int i = 0; i < W; i++) begin
            row0_c[i] = col[i][0];
            row1_c[i] = col[i][1];
        end
    end

    // Whole pipeline freezes on stall; data registers load regardless of valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            v3   <= 1'b0;
            a1   <= '0;
            b1   <= '0;
            s1   <= 1'b0;
            r0_q <= '0;
            r1_q <= '0;
            y_q  <= '0;
        end else if (!stall) begin
            v1   <= bus.in_valid;
            a1   <= bus.A;
            b1   <= bus.B;
            s1   <= bus.signed_mode;
            v2   <= v1;
            r0_q <= row0_c;
            r1_q <= row1_c;
            v3   <= v2;
            y_q  <= r0_q + r1_q;
        end
    end
endmodule

// File: tb/tb_dadda_pipe_mul.sv
// Scoreboard bench for dadda_pipe_mul: an 8x8 and a 12x6 instance checked against an arithmetic model.
module tb_dadda_pipe_mul;
    logic clk = 1'b0;
    logic rst8, rst12;
    always #5 clk = ~clk;

    dadda_pipe_mul_if #(.N(8),  .M(8)) b8  ();
    dadda_pipe_mul_if #(.N(12), .M(6)) b12 ();

    dadda_pipe_mul #(.N(8),  .M(8)) u8  (.clk(clk), .rst(rst8),  .bus(b8));
    dadda_pipe_mul #(.N(12), .M(6)) u12 (.clk(clk), .rst(rst12), .bus(b12));

    typedef struct {
        logic [63:0] exp;
        int          cyc;
        bit          chk_lat;
    } item_t;

    item_t       q8[$];
    item_t       q12[$];
    item_t       it8, it12;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          got8 = 0;
    int          got12 = 0;
    bit          lat_mode = 1'b1;
    bit          send_done;
    bit          prev_stall8 = 1'b0;
    logic [15:0] prev_y8 = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Exact product from the operands' numeric values, reduced to n+m bits.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input int n, input int m, input logic s);
        longint sa, sb;
        sa = longint'(a);
        sb = longint'(b);
        if (s && a[n-1]) sa = sa - (longint'(1) << n);
        if (s && b[m-1]) sb = sb - (longint'(1) << m);
        return 64'(sa * sb) & ((64'd1 << (n + m)) - 64'd1);
    endfunction

    // 8x8 monitor: scoreboard pops, handshake rule, stall stability.
    always @(negedge clk) begin
        if (rst8) begin
            check("in_ready_rst8", 64'(b8.in_ready), 64'd0);
            q8.delete();
            prev_stall8 = 1'b0;
        end else begin
            check("in_ready8", 64'(b8.in_ready), 64'(!(b8.out_valid && !b8.out_ready)));
            if (prev_stall8) begin
                check("hold_valid8", 64'(b8.out_valid), 64'd1);
                check("hold_y8", 64'(b8.y), 64'(prev_y8));
            end
            if (b8.out_valid && b8.out_ready) begin
                if (q8.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious8: got y=0x%0h, required no output", b8.y);
                end else begin
                    it8 = q8.pop_front();
                    check("y8", 64'(b8.y), it8.exp);
                    if (it8.chk_lat) check("lat8", 64'(cyc - it8.cyc), 64'd3);
                    got8++;
                end
            end
            if (b8.in_valid && b8.in_ready)
                q8.push_back('{ref_mul(32'(b8.A), 32'(b8.B), 8, 8, b8.signed_mode), cyc, lat_mode});
            prev_stall8 = b8.out_valid && !b8.out_ready;
            prev_y8     = b8.y;
        end
    end

    // 12x6 monitor.
    always @(negedge clk) begin
        if (rst12) begin
            q12.delete();
        end else begin
            check("in_ready12", 64'(b12.in_ready), 64'(!(b12.out_valid && !b12.out_ready)));
            if (b12.out_valid && b12.out_ready) begin
                if (q12.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious12: got y=0x%0h, required no output", b12.y);
                end else begin
                    it12 = q12.pop_front();
                    check("y12", 64'(b12.y), it12.exp);
                    if (it12.chk_lat) check("lat12", 64'(cyc - it12.cyc), 64'd3);
                    got12++;
                end
            end
            if (b12.in_valid && b12.in_ready)
                q12.push_back('{ref_mul(32'(b12.A), 32'(b12.B), 12, 6, b12.signed_mode), cyc, 1'b1});
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int k = 0;
        b8.in_valid = 1'b1;
        b8.A = a;
        b8.B = b;
        b8.signed_mode = s;
        @(negedge clk);
        while (!b8.in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            total++;
            bad++;
            $display("FAIL accept8: got no in_ready in %0d cycles, required acceptance", k);
        end
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
    endtask

    task automatic send12(input logic [11:0] a, input logic [5:0] b, input logic s);
        int k = 0;
        b12.in_valid = 1'b1;
        b12.A = a;
        b12.B = b;
        b12.signed_mode = s;
        @(negedge clk);
        while (!b12.in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            total++;
            bad++;
            $display("FAIL accept12: got no in_ready in %0d cycles, required acceptance", k);
        end
        @(posedge clk);
        #1;
        b12.in_valid = 1'b0;
    endtask

    task automatic drain8();
        int k = 0;
        while (q8.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("drain8", 64'(q8.size()), 64'd0);
    endtask

    task automatic drain12();
        int k = 0;
        while (q12.size() != 0 && k < 300) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("drain12", 64'(q12.size()), 64'd0);
    endtask

    initial begin
        int base;
        rst8 = 1'b1;
        rst12 = 1'b1;
        b8.in_valid = 1'b0;  b8.A = '0;  b8.B = '0;  b8.signed_mode = 1'b0;  b8.out_ready = 1'b1;
        b12.in_valid = 1'b0; b12.A = '0; b12.B = '0; b12.signed_mode = 1'b0; b12.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst8 = 1'b0;
        rst12 = 1'b0;
        @(negedge clk);
        check("rst_out_valid8", 64'(b8.out_valid), 64'd0);
        check("rst_y8", 64'(b8.y), 64'd0);
        check("rst_in_ready8", 64'(b8.in_ready), 64'd1);
        check("rst_out_valid12", 64'(b12.out_valid), 64'd0);
        check("rst_y12", 64'(b12.y), 64'd0);
        @(posedge clk);
        #1;

        // Directed unsigned and signed corners, out_ready high.
        send8(8'd250, 8'd250, 1'b0);
        send8(8'd255, 8'd255, 1'b0);
        send8(8'd0,   8'd200, 1'b0);
        send8(8'h80,  8'h80,  1'b1);
        send8(8'h80,  8'h7F,  1'b1);
        send8(8'hFF,  8'h01,  1'b1);
        send8(8'd7,   8'hFD,  1'b1);
        drain8();

        // Back-to-back mixed-mode stream.
        for (int i = 0; i < 1000; i++)
            send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
        drain8();

        // Random backpressure with random input gaps.
        lat_mode = 1'b0;
        send_done = 1'b0;
        base = got8;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
                end
                send_done = 1'b1;
            end
            begin
                for (int c = 0; c < 5000 && !send_done; c++) begin
                    @(posedge clk);
                    #1;
                    b8.out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        b8.out_ready = 1'b1;
        drain8();
        check("count8", 64'(got8 - base), 64'd300);

        // Fill the pipeline under backpressure, then reset: nothing may emerge.
        lat_mode = 1'b1;
        @(posedge clk);
        #1;
        b8.out_ready = 1'b0;
        send8(8'd11, 8'd13, 1'b0);
        send8(8'hF0, 8'd3,  1'b1);
        send8(8'd99, 8'd99, 1'b0);
        @(negedge clk);
        check("inflight8", 64'(q8.size()), 64'd3);
        check("full_in_ready8", 64'(b8.in_ready), 64'd0);
        @(posedge clk);
        #1;
        rst8 = 1'b1;
        @(posedge clk);
        #1;
        rst8 = 1'b0;
        b8.out_ready = 1'b1;
        base = got8;
        repeat (6) begin
            @(negedge clk);
            check("no_emerge8", 64'(b8.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send8(8'h81, 8'd5, 1'b1);
        drain8();
        check("post_rst_count8", 64'(got8 - base), 64'd1);

        // Non-square widths.
        send12(12'd4095, 6'd63,  1'b0);
        send12(12'h800,  6'h20,  1'b1);
        send12(12'hFFF,  6'h01,  1'b1);
        send12(12'h7FF,  6'h20,  1'b1);
        for (int i = 0; i < 40; i++)
            send12(12'($urandom), 6'($urandom), 1'($urandom_range(0, 1)));
        drain12();
        check("count12", 64'(got12), 64'd44);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
